// File: rtl/gf180mcu_latch_bank_pkg.sv
// Shared types and constants for the latch bank write/preset sequencer.
package gf180mcu_latch_bank_pkg;

  // Phase lengths up to 255 cycles fit in the counter.
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    PRESET
  } state_e;

endpackage

// File: rtl/gf180mcu_latch_bank_phase_cnt.sv
// Loadable down-counter with zero flag; times every sequencer phase.
module gf180mcu_latch_bank_phase_cnt
  import gf180mcu_latch_bank_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/gf180mcu_latch_bank_ctrl.sv
// Setup/pulse/hold write sequencer and bank preset control for a latch array.
module gf180mcu_latch_bank_ctrl
  import gf180mcu_latch_bank_pkg::*;
#(
  parameter  int WORDS      = 8,
  parameter  int WIDTH      = 8,
  parameter  int SETUP_CYC  = 1,
  parameter  int PULSE_CYC  = 2,
  parameter  int HOLD_CYC   = 1,
  parameter  int PRESET_CYC = 2,
  localparam int ADDR_W     = $clog2(WORDS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [WIDTH-1:0]  WR_DATA,
  input  logic              PRESET_REQ,
  output logic              PRESET_ACK,
  output logic [WORDS-1:0]  LE,
  output logic [WIDTH-1:0]  LD,
  output logic              LSETN,
  output logic              BUSY
);

  state_e            state_q, state_d;
  logic              preset_pend, pend_d;
  logic [ADDR_W-1:0] addr_q;
  logic [WORDS-1:0]  le_d;
  logic              cnt_zero;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              accept;
  logic              preset_want;
  logic              addr_ok;

  assign preset_want = PRESET_REQ || preset_pend;
  assign WR_READY    = (state_q == IDLE) && !PRESET_REQ && !preset_pend;
  assign accept      = WR_VALID && WR_READY;
  assign BUSY        = (state_q != IDLE);
  assign addr_ok     = ({1'b0, addr_q} < (ADDR_W + 1)'(WORDS));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (preset_want)   state_d = PRESET;
        else if (WR_VALID) state_d = SETUP;
      end
      SETUP:  if (cnt_zero) state_d = PULSE;
      PULSE:  if (cnt_zero) state_d = HOLD;
      // A preset queued behind a write starts straight after its hold phase.
      HOLD:   if (cnt_zero) state_d = preset_want ? PRESET : IDLE;
      PRESET: if (cnt_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_load     = (state_d != state_q);
    cnt_load_val = '0;
    case (state_d)
      SETUP:   cnt_load_val = CNT_W'(SETUP_CYC - 1);
      PULSE:   cnt_load_val = CNT_W'(PULSE_CYC - 1);
      HOLD:    cnt_load_val = CNT_W'(HOLD_CYC - 1);
      PRESET:  cnt_load_val = CNT_W'(PRESET_CYC - 1);
      default: cnt_load_val = '0;
    endcase
  end

  // Requests arriving during PRESET, or on the cycle it is entered, merge into that preset.
  always_comb begin
    pend_d = preset_pend;
    if (PRESET_REQ && (state_q != PRESET)) pend_d = 1'b1;
    if ((state_d == PRESET) && (state_q != PRESET)) pend_d = 1'b0;
  end

  always_comb begin
    le_d = '0;
    if ((state_d == PULSE) && addr_ok) le_d[addr_q] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      preset_pend <= 1'b0;
      addr_q      <= '0;
      LD          <= '0;
      LE          <= '0;
      LSETN       <= 1'b1;
      PRESET_ACK  <= 1'b0;
    end else begin
      state_q     <= state_d;
      preset_pend <= pend_d;
      if (accept) begin
        addr_q <= WR_ADDR;
        LD     <= WR_DATA;
      end
      LE         <= le_d;
      LSETN      <= (state_d != PRESET);
      PRESET_ACK <= (state_q == PRESET) && (state_d == IDLE);
    end
  end

  gf180mcu_latch_bank_phase_cnt u_phase_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

endmodule

// File: tb/tb_gf180mcu_latch_bank_ctrl.sv
// Directed bench for the latch bank sequencer: default 8-word bank plus a 10-word bank.
module tb_gf180mcu_latch_bank_ctrl;

  logic       clk;
  logic       rst;

  logic       wr_valid, wr_ready, preset_req, preset_ack, lsetn, busy;
  logic [2:0] wr_addr;
  logic [7:0] wr_data, ld, le;

  logic       b_wr_valid, b_wr_ready, b_preset_req, b_preset_ack, b_lsetn, b_busy;
  logic [3:0] b_wr_addr;
  logic [7:0] b_wr_data, b_ld;
  logic [9:0] b_le;

  int tests;
  int failed;
  int ack_cnt;
  int overlap_cnt;

  gf180mcu_latch_bank_ctrl u_dut8 (
    .CLK(clk), .RST(rst), .WR_VALID(wr_valid), .WR_READY(wr_ready),
    .WR_ADDR(wr_addr), .WR_DATA(wr_data), .PRESET_REQ(preset_req),
    .PRESET_ACK(preset_ack), .LE(le), .LD(ld), .LSETN(lsetn), .BUSY(busy)
  );

  gf180mcu_latch_bank_ctrl #(.WORDS(10)) u_dut10 (
    .CLK(clk), .RST(rst), .WR_VALID(b_wr_valid), .WR_READY(b_wr_ready),
    .WR_ADDR(b_wr_addr), .WR_DATA(b_wr_data), .PRESET_REQ(b_preset_req),
    .PRESET_ACK(b_preset_ack), .LE(b_le), .LD(b_ld), .LSETN(b_lsetn), .BUSY(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (preset_ack) ack_cnt++;
    if ((le != '0) && !lsetn) overlap_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: run exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0; failed = 0; ack_cnt = 0; overlap_cnt = 0;
    rst = 1'b1;
    wr_valid = 0; wr_addr = '0; wr_data = '0; preset_req = 0;
    b_wr_valid = 0; b_wr_addr = '0; b_wr_data = '0; b_preset_req = 0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_le", 32'(le), 32'h0);
    check("rst_ld", 32'(ld), 32'h0);
    check("rst_lsetn", 32'(lsetn), 32'h1);
    check("rst_ack", 32'(preset_ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'(wr_ready), 32'h1);

    // Single write addr 3 data A5, accepted at edge t
    wr_valid = 1; wr_addr = 3'd3; wr_data = 8'hA5;
    tick(); wr_valid = 0; wr_data = 8'h00;                // cycle t+1
    check("w1_ld_t1", 32'(ld), 32'hA5);
    check("w1_le_t1", 32'(le), 32'h0);
    check("w1_rdy_t1", 32'(wr_ready), 32'h0);
    check("w1_busy_t1", 32'(busy), 32'h1);
    tick();                                               // t+2
    check("w1_le_t2", 32'(le), 32'h08);
    check("w1_rdy_t2", 32'(wr_ready), 32'h0);
    tick();                                               // t+3
    check("w1_le_t3", 32'(le), 32'h08);
    check("w1_rdy_t3", 32'(wr_ready), 32'h0);
    tick();                                               // t+4
    check("w1_le_t4", 32'(le), 32'h0);
    check("w1_rdy_t4", 32'(wr_ready), 32'h0);
    tick();                                               // t+5
    check("w1_rdy_t5", 32'(wr_ready), 32'h1);
    check("w1_busy_t5", 32'(busy), 32'h0);
    check("w1_ld_hold", 32'(ld), 32'hA5);

    // Preset alone
    ack_cnt = 0;
    preset_req = 1;
    #1 check("p1_rdy_req", 32'(wr_ready), 32'h0);
    tick(); preset_req = 0;                               // t+1
    check("p1_lsetn_t1", 32'(lsetn), 32'h0);
    check("p1_le_t1", 32'(le), 32'h0);
    check("p1_busy_t1", 32'(busy), 32'h1);
    tick();                                               // t+2
    check("p1_lsetn_t2", 32'(lsetn), 32'h0);
    check("p1_ack_t2", 32'(preset_ack), 32'h0);
    tick();                                               // t+3
    check("p1_lsetn_t3", 32'(lsetn), 32'h1);
    check("p1_ack_t3", 32'(preset_ack), 32'h1);
    check("p1_busy_t3", 32'(busy), 32'h0);
    tick();                                               // t+4
    check("p1_ack_t4", 32'(preset_ack), 32'h0);
    check("p1_ack_count", 32'(ack_cnt), 32'd1);

    // Preset requested during a write's PULSE
    ack_cnt = 0; overlap_cnt = 0;
    wr_valid = 1; wr_addr = 3'd5; wr_data = 8'h5A;
    tick(); wr_valid = 0;                                 // t+1 SETUP
    tick(); preset_req = 1;                               // t+2 PULSE
    check("p2_le_t2", 32'(le), 32'h20);
    tick(); preset_req = 0;                               // t+3 PULSE
    check("p2_le_t3", 32'(le), 32'h20);
    check("p2_lsetn_t3", 32'(lsetn), 32'h1);
    tick();                                               // t+4 HOLD
    check("p2_le_t4", 32'(le), 32'h0);
    check("p2_lsetn_t4", 32'(lsetn), 32'h1);
    tick();                                               // t+5 PRESET
    check("p2_lsetn_t5", 32'(lsetn), 32'h0);
    check("p2_le_t5", 32'(le), 32'h0);
    tick();                                               // t+6
    check("p2_lsetn_t6", 32'(lsetn), 32'h0);
    tick();                                               // t+7
    check("p2_ack_t7", 32'(preset_ack), 32'h1);
    check("p2_lsetn_t7", 32'(lsetn), 32'h1);
    tick(); tick(); tick();
    check("p2_ack_count", 32'(ack_cnt), 32'd1);
    check("p2_overlap", 32'(overlap_cnt), 32'd0);
    check("p2_ld", 32'(ld), 32'h5A);

    // Simultaneous write and preset in IDLE
    ack_cnt = 0;
    wr_valid = 1; wr_addr = 3'd1; wr_data = 8'h3C; preset_req = 1;
    #1 check("s_rdy_req", 32'(wr_ready), 32'h0);
    tick(); preset_req = 0;                               // PRESET 1
    check("s_lsetn_1", 32'(lsetn), 32'h0);
    check("s_rdy_1", 32'(wr_ready), 32'h0);
    tick();                                               // PRESET 2
    check("s_lsetn_2", 32'(lsetn), 32'h0);
    tick();                                               // IDLE with ack, write accepted here
    check("s_ack", 32'(preset_ack), 32'h1);
    check("s_rdy_idle", 32'(wr_ready), 32'h1);
    check("s_ld_before", 32'(ld), 32'h5A);
    tick(); wr_valid = 0;                                 // SETUP
    check("s_ld_after", 32'(ld), 32'h3C);
    check("s_le_setup", 32'(le), 32'h0);
    tick();
    check("s_le_p1", 32'(le), 32'h02);
    tick();
    check("s_le_p2", 32'(le), 32'h02);
    tick();
    check("s_le_hold", 32'(le), 32'h0);
    tick();
    check("s_rdy_back", 32'(wr_ready), 32'h1);
    check("s_ack_count", 32'(ack_cnt), 32'd1);

    // 10-word bank: addr 9 in range, addr 10 out of range
    b_wr_valid = 1; b_wr_addr = 4'd9; b_wr_data = 8'h99;
    tick(); b_wr_valid = 0;
    check("b9_ld", 32'(b_ld), 32'h99);
    tick();
    check("b9_le_p1", 32'(b_le), 32'h200);
    tick();
    check("b9_le_p2", 32'(b_le), 32'h200);
    tick();
    check("b9_le_hold", 32'(b_le), 32'h0);
    tick();
    check("b9_rdy", 32'(b_wr_ready), 32'h1);
    b_wr_valid = 1; b_wr_addr = 4'd10; b_wr_data = 8'h77;
    tick(); b_wr_valid = 0;
    check("b10_ld", 32'(b_ld), 32'h77);
    check("b10_busy_t1", 32'(b_busy), 32'h1);
    tick();
    check("b10_le_p1", 32'(b_le), 32'h0);
    check("b10_busy_t2", 32'(b_busy), 32'h1);
    tick();
    check("b10_le_p2", 32'(b_le), 32'h0);
    tick();
    check("b10_rdy_t4", 32'(b_wr_ready), 32'h0);
    tick();
    check("b10_rdy_t5", 32'(b_wr_ready), 32'h1);
    check("b10_busy_t5", 32'(b_busy), 32'h0);

    // Reset in the second PULSE cycle with a preset pending
    ack_cnt = 0;
    wr_valid = 1; wr_addr = 3'd2; wr_data = 8'hF0;
    tick(); wr_valid = 0;                                 // SETUP
    tick(); preset_req = 1;                               // PULSE 1
    check("r_le_p1", 32'(le), 32'h04);
    tick(); preset_req = 0; rst = 1;                      // PULSE 2
    check("r_le_p2", 32'(le), 32'h04);
    tick(); rst = 0;
    check("r_le", 32'(le), 32'h0);
    check("r_lsetn", 32'(lsetn), 32'h1);
    check("r_ld", 32'(ld), 32'h0);
    check("r_busy", 32'(busy), 32'h0);
    check("r_rdy", 32'(wr_ready), 32'h1);
    tick();
    check("r_lsetn_after1", 32'(lsetn), 32'h1);
    check("r_busy_after1", 32'(busy), 32'h0);
    tick(); tick();
    check("r_lsetn_after3", 32'(lsetn), 32'h1);
    check("r_rdy_after3", 32'(wr_ready), 32'h1);
    check("r_ack_count", 32'(ack_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/gf180mcu_latch_bank_ctrl.md
# gf180mcu_latch_bank_ctrl

Write/preset sequencer for a bank of WORDS x WIDTH transparent high-enable latches with active-low set (latsnq-style storage). It takes write requests over a valid/ready handshake and drives the bank's per-word enables, shared data bus and bank-wide set line. Every operation runs a fixed setup/pulse/hold sequence, so latch timing is met by construction. It sits between a register-file front end and the latch array; reads are combinational from the latch Q outputs and do not involve this block.

## Interface
- WORDS, 8: number of latch words; ≥2.
- WIDTH, 8: bits per word.
- SETUP_CYC, 1: cycles LD is stable before LE rises; ≥1.
- PULSE_CYC, 2: cycles LE is high; ≥1.
- HOLD_CYC, 1: cycles LD stays stable after LE falls; ≥1.
- PRESET_CYC, 2: cycles LSETN is held low; ≥1.
- ADDR_W, $clog2(WORDS): derived; not overridden.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- WR_VALID  in  1  write request valid.
- WR_READY  out  1  write request accepted when WR_VALID && WR_READY.
- WR_ADDR  in  ADDR_W  target word.
- WR_DATA  in  WIDTH  write data.
- PRESET_REQ  in  1  single-cycle pulse requesting a set of all words to 1.
- PRESET_ACK  out  1  single-cycle pulse when a preset completes.
- LE  out  WORDS  one-hot/zero latch enables (to cell E).
- LD  out  WIDTH  latch data bus (to cell D).
- LSETN  out  1  bank-wide active-low set (to cell SETN).
- BUSY  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SETUP, PULSE, HOLD, PRESET.
- IDLE: LE=0, LSETN=1. WR_READY = IDLE && !PRESET_REQ && !preset_pend.
- preset_pend: set by PRESET_REQ in any state; cleared on entry to PRESET. Repeated requests while pending or in PRESET merge into one.
- Priority in IDLE: a pending or same-cycle preset goes to PRESET. Otherwise an accepted write goes to SETUP.
- On accept: WR_DATA is registered to LD and WR_ADDR to the address register. LD holds that value until the next accept.
- SETUP lasts SETUP_CYC cycles, then PULSE.
- PULSE lasts PULSE_CYC cycles with LE[addr]=1 and all other LE bits 0, then HOLD.
- HOLD lasts HOLD_CYC cycles with LE=0, then IDLE.
- Out-of-range address (addr ≥ WORDS): the write is accepted and runs the full sequence, but LE stays 0.
- PRESET lasts PRESET_CYC cycles with LSETN=0 and LE=0, then IDLE. PRESET_ACK=1 on the first IDLE cycle after PRESET.
- LE and LSETN=0 are never active in the same cycle. A preset never interrupts a write; it waits until HOLD completes.
- Phase lengths are set by one down-counter, loaded on each state entry with (param-1). The state advances when the counter is 0.

## Timing
- All outputs are registered; no combinational path from inputs to LE, LD or LSETN. WR_READY is combinational from state, preset_pend and PRESET_REQ.
- Write accepted at edge t:
  - SETUP covers cycles t+1 .. t+SETUP_CYC.
  - LE is high for cycles t+SETUP_CYC+1 .. t+SETUP_CYC+PULSE_CYC.
  - WR_READY returns at t+SETUP_CYC+PULSE_CYC+HOLD_CYC+1.
  - Defaults: LE high in cycles t+2 and t+3; WR_READY high again at t+5.
- Preset entered at edge t: LSETN is low for cycles t+1 .. t+PRESET_CYC, and PRESET_ACK is high at t+PRESET_CYC+1.
- Back-to-back writes: the minimum issue interval is SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles.
- Reset values: state IDLE, LE=0, LD=0, LSETN=1, PRESET_ACK=0, BUSY=0, preset_pend=0, counter=0.
- RST mid-operation forces these values at the next edge. An interrupted pulse or preset is truncated; latch contents are not modified by RST.

## Structure
- Package gf180mcu_latch_bank_pkg holds the state enum (IDLE, SETUP, PULSE, HOLD, PRESET) and the counter width constant, sized for max(param) ≤ 255.
- Sub-module gf180mcu_latch_bank_phase_cnt: a loadable down-counter with a zero flag, used for all phases.
- The FSM, preset_pend, the LD/address registers and the one-hot LE decode live in the top module.

## Test plan
- Reset then a single write to addr 3, data 0xA5 (defaults):
  - LD=0xA5 from t+1.
  - LE=0x08 exactly in cycles t+2 and t+3.
  - WR_READY=0 during t+1..t+4 and 1 at t+5.
- Preset alone: PRESET_REQ pulse in IDLE gives LSETN=0 for 2 cycles, LE=0 throughout, PRESET_ACK for one cycle, then BUSY=0.
- Preset during a write's PULSE:
  - The write completes unchanged and LE is never active while LSETN=0.
  - PRESET starts on the cycle after HOLD; exactly one PRESET_ACK.
- Simultaneous WR_VALID and PRESET_REQ in IDLE: WR_READY=0, preset runs first, then the write (addr 1, 0x3C) is accepted and LE=0x02 pulses.
- Write to addr 9 with WORDS=10 then addr 10: addr 9 gives LE[9] high for the pulse; addr 10 runs full latency with LE=0.
- RST asserted in the second PULSE cycle: the next edge gives LE=0, LSETN=1, LD=0, BUSY=0 and WR_READY=1; a pending preset is discarded.
